wb_sram_bridge: RTL and testbench
=================================

// Module: wb_sram_bridge
// PURPOSE
//  Wishbone classic slave placed directly downstream of the MIPS Wishbone arbiter (icache/data port mux).
//  Converts each 32-bit Wishbone access into one or two 16-bit accesses on an external asynchronous SRAM.
//  Timing is set by a programmable wait-state count. Responds to every address; no decoding.
// PARAMETERS
//  AWIDTH  18  Wishbone word-address width; SRAM half-word address is AWIDTH+1 bits
//  WAIT    1   extra strobe cycles per half access (0..15); strobe length = WAIT+1 cycles
// PORTS
//  i_clk          in   1         clock, rising edge
//  i_rb           in   1         asynchronous reset, active low
//  i_wb_cyc       in   1         bus cycle
//  i_wb_stb       in   1         strobe
//  i_wb_we        in   1         1 = write
//  i_wb_sel       in   4         byte enables, [0] = bits 7:0
//  i_wb_adr       in   AWIDTH    word address
//  i_wb_dat       in   32        write data
//  o_wb_dat       out  32        read data, valid while o_wb_ack=1
//  o_wb_ack       out  1         single-cycle acknowledge
//  o_sram_addr    out  AWIDTH+1  half-word address {adr, half}, half 0 = bits 15:0
//  o_sram_ce_n    out  1         chip enable, active low
//  o_sram_oe_n    out  1         output enable, active low
//  o_sram_we_n    out  1         write enable, active low
//  o_sram_lb_n    out  1         low-byte lane enable, active low
//  o_sram_ub_n    out  1         high-byte lane enable, active low
//  o_sram_dq      out  16        write data to pad
//  o_sram_dq_oe   out  1         1 = top-level tristate drives o_sram_dq
//  i_sram_dq      in   16        read data from pad
// BEHAVIOUR
//  Reset (i_rb=0, async): state IDLE; ce_n=oe_n=we_n=lb_n=ub_n=1; dq_oe=0; addr, dq, o_wb_dat = 0; ack = 0.
//  All SRAM outputs and o_wb_dat are registered and change on the same edge that changes state.
//  FSM states: IDLE, SETUP, STROBE, ACK. Wait counter counts WAIT down to 0 in STROBE.
//  IDLE: on cyc&stb, latch adr/we/sel/dat.
//   Write with sel==0000 goes directly to ACK.
//   Read, or write with sel[1:0]!=0, goes to SETUP for half 0.
//   Otherwise (write, sel[1:0]==0) goes to SETUP for half 1.
//  SETUP (1 cycle): addr={adr,half}; ce_n=0; we_n=1.
//   Read: oe_n=0, lb_n=ub_n=0. Write: oe_n=1, dq_oe=1, dq=selected half; lb_n/ub_n = ~sel lanes of that half.
//   Next state is STROBE.
//  STROBE (WAIT+1 cycles): controls as in SETUP; write additionally drives we_n=0.
//   On the final STROBE cycle edge:
//   - read: capture i_sram_dq into o_wb_dat half.
//   - write: we_n returns to 1 and dq_oe stays 1 for this edge (data hold).
//   Then go to SETUP for half 1 if still needed (half 0 done; read, or sel[3:2]!=0), else ACK.
//   Reads always access both halves; sel is ignored for reads.
//  ACK (1 cycle): SRAM idle (all _n=1, dq_oe=0); o_wb_ack = i_wb_cyc & i_wb_stb; then IDLE.
//   No back-to-back issue from ACK. A new request is accepted at the earliest in the following IDLE cycle.
//  Latency from first cycle of stb to ack cycle, counting that cycle as 0:
//   read = 2*(WAIT+2)+1; single-half write = (WAIT+2)+1; sel==0000 write = 1.
//  Abort: cyc or stb low in SETUP -> IDLE next edge, no SRAM strobe.
//   Abort in STROBE -> current strobe completes, then IDLE, no ack.
//  Reset mid-operation: we_n/ce_n go to 1 asynchronously; no partial ack is ever produced.
//  dq_oe is never 1 while oe_n=0.
// TESTING
//  1 Reset: assert i_rb=0 mid-STROBE of a write -> we_n=1, ce_n=1, dq_oe=0 within the same cycle; ack=0.
//  2 Read WAIT=1, adr=0x00010; model returns 0x1234 @0x20 and 0xABCD @0x21 -> ack in cycle 7, o_wb_dat=0xABCD1234.
//  3 Write sel=1111, dat=0xDEADBEEF, WAIT=1 -> two 2-cycle we_n pulses, dq 0xBEEF then 0xDEAD, lb_n=ub_n=0; ack in cycle 7.
//  4 Write sel=0100, dat=0x00550000, WAIT=1 -> one access only, addr half=1, ub_n=1, lb_n=0, dq=0x0055; ack in cycle 4.
//  5 Write sel=0000 -> ack in cycle 1, ce_n stays 1 throughout.
//  6 Read with stb dropped during the first STROBE -> strobe finishes, no ack, FSM back in IDLE.
//    Next read then completes normally with correct data.

Source files
------------

// File: rtl/wb_sram_bridge.sv
// rtl/wb_sram_bridge.sv - Wishbone classic slave to 16-bit asynchronous SRAM bridge
// Splits each 32-bit access into one or two half-word SRAM accesses with programmable strobe length.
module wb_sram_bridge #(
    parameter int AWIDTH = 18,
    parameter int WAIT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rb,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [3:0]        i_wb_sel,
    input  logic [AWIDTH-1:0] i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic [AWIDTH:0]   o_sram_addr,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    output logic [15:0]       o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

    state_t            state, state_n;
    logic              half, half_n;
    logic              lat_we, lat_we_n;
    logic [3:0]        lat_sel, lat_sel_n;
    logic [AWIDTH-1:0] lat_adr, lat_adr_n;
    logic [31:0]       lat_dat, lat_dat_n;
    logic [3:0]        wait_cnt, wait_cnt_n;
    logic              abort_q, abort_n;

    logic [AWIDTH:0]   addr_n;
    logic              ce_n_n, oe_n_n, we_n_n, lb_n_n, ub_n_n, dq_oe_n;
    logic [15:0]       dq_n;
    logic [31:0]       wb_dat_n;

    logic              req;
    logic              drive, strobe, hold_oe;
    logic              src_we;
    logic [3:0]        src_sel;
    logic [AWIDTH-1:0] src_adr;
    logic [31:0]       src_dat;

    assign req = i_wb_cyc & i_wb_stb;

    // In IDLE the request is not latched yet, so the first SETUP is built from the bus directly.
    assign src_we  = (state == IDLE) ? i_wb_we  : lat_we;
    assign src_sel = (state == IDLE) ? i_wb_sel : lat_sel;
    assign src_adr = (state == IDLE) ? i_wb_adr : lat_adr;
    assign src_dat = (state == IDLE) ? i_wb_dat : lat_dat;

    assign o_wb_ack = (state == ACK) & req;

    always_comb begin
        state_n    = state;
        half_n     = half;
        lat_we_n   = lat_we;
        lat_sel_n  = lat_sel;
        lat_adr_n  = lat_adr;
        lat_dat_n  = lat_dat;
        wait_cnt_n = wait_cnt;
        abort_n    = abort_q;
        wb_dat_n   = o_wb_dat;
        addr_n     = o_sram_addr;
        dq_n       = o_sram_dq;
        ce_n_n     = 1'b1;
        oe_n_n     = 1'b1;
        we_n_n     = 1'b1;
        lb_n_n     = 1'b1;
        ub_n_n     = 1'b1;
        dq_oe_n    = 1'b0;
        drive      = 1'b0;
        strobe     = 1'b0;
        hold_oe    = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    lat_we_n  = i_wb_we;
                    lat_sel_n = i_wb_sel;
                    lat_adr_n = i_wb_adr;
                    lat_dat_n = i_wb_dat;
                    abort_n   = 1'b0;
                    if (i_wb_we && (i_wb_sel == 4'b0000)) begin
                        state_n = ACK;
                    end else begin
                        half_n  = i_wb_we && (i_wb_sel[1:0] == 2'b00);
                        state_n = SETUP;
                        drive   = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (!req) begin
                    state_n = IDLE;
                end else begin
                    state_n    = STROBE;
                    wait_cnt_n = 4'(WAIT);
                    abort_n    = 1'b0;
                    drive      = 1'b1;
                    strobe     = 1'b1;
                end
            end
            STROBE: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_n = wait_cnt - 4'd1;
                    abort_n    = abort_q | ~req;
                    drive      = 1'b1;
                    strobe     = 1'b1;
                end else begin
                    // Last strobe edge: we_n rises while write data stays driven one more cycle.
                    hold_oe = lat_we;
                    abort_n = 1'b0;
                    if (!lat_we) begin
                        if (half) wb_dat_n[31:16] = i_sram_dq;
                        else      wb_dat_n[15:0]  = i_sram_dq;
                    end
                    if (abort_q || !req) begin
                        state_n = IDLE;
                    end else if (!half && (!lat_we || (lat_sel[3:2] != 2'b00))) begin
                        half_n  = 1'b1;
                        state_n = SETUP;
                        drive   = 1'b1;
                    end else begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (drive) begin
            ce_n_n = 1'b0;
            addr_n = {src_adr, half_n};
            if (src_we) begin
                oe_n_n  = 1'b1;
                dq_oe_n = 1'b1;
                dq_n    = half_n ? src_dat[31:16] : src_dat[15:0];
                lb_n_n  = half_n ? ~src_sel[2] : ~src_sel[0];
                ub_n_n  = half_n ? ~src_sel[3] : ~src_sel[1];
                we_n_n  = ~strobe;
            end else begin
                oe_n_n = 1'b0;
                lb_n_n = 1'b0;
                ub_n_n = 1'b0;
            end
        end
        if (hold_oe) begin
            dq_oe_n = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rb) begin
        if (!i_rb) begin
            state        <= IDLE;
            half         <= 1'b0;
            lat_we       <= 1'b0;
            lat_sel      <= 4'b0000;
            lat_adr      <= '0;
            lat_dat      <= 32'd0;
            wait_cnt     <= 4'd0;
            abort_q      <= 1'b0;
            o_wb_dat     <= 32'd0;
            o_sram_addr  <= '0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_sram_dq    <= 16'd0;
            o_sram_dq_oe <= 1'b0;
        end else begin
            state        <= state_n;
            half         <= half_n;
            lat_we       <= lat_we_n;
            lat_sel      <= lat_sel_n;
            lat_adr      <= lat_adr_n;
            lat_dat      <= lat_dat_n;
            wait_cnt     <= wait_cnt_n;
            abort_q      <= abort_n;
            o_wb_dat     <= wb_dat_n;
            o_sram_addr  <= addr_n;
            o_sram_ce_n  <= ce_n_n;
            o_sram_oe_n  <= oe_n_n;
            o_sram_we_n  <= we_n_n;
            o_sram_lb_n  <= lb_n_n;
            o_sram_ub_n  <= ub_n_n;
            o_sram_dq    <= dq_n;
            o_sram_dq_oe <= dq_oe_n;
        end
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb/tb_wb_sram_bridge.sv - directed scoreboard bench for wb_sram_bridge with a behavioural SRAM
module tb_wb_sram_bridge;

    logic        clk = 1'b0;
    logic        rb;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [17:0] adr;
    logic [31:0] wdat;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic [18:0] o_sram_addr;
    logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;
    logic [15:0] o_sram_dq;
    logic        o_sram_dq_oe;
    logic [15:0] i_sram_dq;

    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int oe_clash = 0;

    typedef struct {
        int          lat;
        logic [31:0] dat;
        logic        is_rd;
        string       tag;
    } xfer_t;

    xfer_t       xfer_q[$];
    logic [63:0] exp_pulse_q[$];

    wb_sram_bridge #(.AWIDTH(18), .WAIT(1)) dut (
        .i_clk        (clk),
        .i_rb         (rb),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_sel     (sel),
        .i_wb_adr     (adr),
        .i_wb_dat     (wdat),
        .o_wb_dat     (o_wb_dat),
        .o_wb_ack     (o_wb_ack),
        .o_sram_addr  (o_sram_addr),
        .o_sram_ce_n  (o_sram_ce_n),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_lb_n  (o_sram_lb_n),
        .o_sram_ub_n  (o_sram_ub_n),
        .o_sram_dq    (o_sram_dq),
        .o_sram_dq_oe (o_sram_dq_oe),
        .i_sram_dq    (i_sram_dq)
    );

    initial forever #5 clk = ~clk;

    assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr[7:0]] : 16'h0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pulse(input logic [18:0] a, input logic [15:0] d,
                                          input logic lb, input logic ub, input logic [7:0] len);
        return {19'd0, a, d, lb, ub, len};
    endfunction

    // SRAM model and write-pulse monitor, sampled mid-cycle.
    initial begin
        logic        in_pulse;
        logic [18:0] p_addr;
        logic [15:0] p_dq;
        logic        p_lb, p_ub;
        logic [7:0]  p_len;
        in_pulse = 1'b0;
        p_addr = '0; p_dq = '0; p_lb = 1'b1; p_ub = 1'b1; p_len = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h20] = 16'h1234;
        mem[8'h21] = 16'hABCD;
        forever begin
            @(negedge clk);
            if (!rb) begin
                in_pulse = 1'b0;
            end else begin
                if (!o_sram_ce_n) ce_cnt++;
                if (o_sram_dq_oe && !o_sram_oe_n) oe_clash++;
                if (!o_sram_we_n) begin
                    if (!in_pulse) begin
                        in_pulse = 1'b1;
                        p_addr = o_sram_addr; p_dq = o_sram_dq;
                        p_lb = o_sram_lb_n;   p_ub = o_sram_ub_n;
                        p_len = 8'd0;
                    end
                    p_len++;
                    if (!o_sram_ce_n && o_sram_dq_oe && !o_sram_lb_n) mem[o_sram_addr[7:0]][7:0]  = o_sram_dq[7:0];
                    if (!o_sram_ce_n && o_sram_dq_oe && !o_sram_ub_n) mem[o_sram_addr[7:0]][15:8] = o_sram_dq[15:8];
                end else if (in_pulse) begin
                    in_pulse = 1'b0;
                    if (exp_pulse_q.size() == 0)
                        chk("unexpected_we_pulse", pulse(p_addr, p_dq, p_lb, p_ub, p_len), 64'd0);
                    else
                        chk("we_pulse", pulse(p_addr, p_dq, p_lb, p_ub, p_len), exp_pulse_q.pop_front());
                end
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [3:0] s, input logic [17:0] a,
                           input logic [31:0] d, input int lat, input logic [31:0] exp_d,
                           input string tag);
        xfer_t e;
        xfer_t got_e;
        logic  got;
        int    n;
        e.lat = lat; e.dat = exp_d; e.is_rd = ~w; e.tag = tag;
        xfer_q.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_wb_ack) begin
                got = 1'b1;
                n = i;
                break;
            end
            @(posedge clk);
        end
        got_e = xfer_q.pop_front();
        chk({got_e.tag, "_ack_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({got_e.tag, "_ack_cycle"}, 64'(n), 64'(got_e.lat));
            if (got_e.is_rd) chk({got_e.tag, "_rdata"}, 64'(o_wb_dat), 64'(got_e.dat));
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        int c0;
        int acks;
        rb = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'b0; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n",  64'(o_sram_ce_n),  64'd1);
        chk("rst_oe_we_lb_ub", 64'({o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 64'hF);
        chk("rst_dq_oe", 64'(o_sram_dq_oe), 64'd0);
        chk("rst_addr_dq_dat", 64'({o_sram_addr, o_sram_dq, o_wb_dat}), 64'd0);
        chk("rst_ack",   64'(o_wb_ack),     64'd0);
        rb = 1'b1;

        // Reset asserted in the middle of a write strobe.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 18'h00040; wdat = 32'h11112222;
        @(posedge clk);
        @(posedge clk); #2;
        chk("t1_we_n_in_strobe", 64'(o_sram_we_n), 64'd0);
        rb = 1'b0;
        #1;
        chk("t1_we_n",  64'(o_sram_we_n),  64'd1);
        chk("t1_ce_n",  64'(o_sram_ce_n),  64'd1);
        chk("t1_dq_oe", 64'(o_sram_dq_oe), 64'd0);
        chk("t1_ack",   64'(o_wb_ack),     64'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rb = 1'b1;

        wb_xfer(1'b0, 4'hF, 18'h00010, 32'h0, 7, 32'hABCD1234, "t2_read");

        exp_pulse_q.push_back(pulse(19'h60, 16'hBEEF, 1'b0, 1'b0, 8'd2));
        exp_pulse_q.push_back(pulse(19'h61, 16'hDEAD, 1'b0, 1'b0, 8'd2));
        wb_xfer(1'b1, 4'b1111, 18'h00030, 32'hDEADBEEF, 7, 32'h0, "t3_write");
        chk("t3_pulses_left", 64'(exp_pulse_q.size()), 64'd0);
        wb_xfer(1'b0, 4'b0000, 18'h00030, 32'h0, 7, 32'hDEADBEEF, "t3_readback");

        exp_pulse_q.push_back(pulse(19'h61, 16'h0055, 1'b0, 1'b1, 8'd2));
        wb_xfer(1'b1, 4'b0100, 18'h00030, 32'h00550000, 4, 32'h0, "t4_write");
        chk("t4_pulses_left", 64'(exp_pulse_q.size()), 64'd0);
        wb_xfer(1'b0, 4'hF, 18'h00030, 32'h0, 7, 32'hDE55BEEF, "t4_readback");

        c0 = ce_cnt;
        wb_xfer(1'b1, 4'b0000, 18'h00031, 32'hFFFFFFFF, 1, 32'h0, "t5_write_nosel");
        chk("t5_ce_cycles", 64'(ce_cnt - c0), 64'd0);

        // Read with stb dropped during the first strobe.
        c0 = ce_cnt;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 18'h00010;
        @(posedge clk);
        @(posedge clk); #1;
        stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_wb_ack) acks++;
        end
        chk("t6_no_ack", 64'(acks), 64'd0);
        chk("t6_ce_cycles", 64'(ce_cnt - c0), 64'd3);
        chk("t6_ce_n_idle", 64'(o_sram_ce_n), 64'd1);
        cyc = 1'b0;
        wb_xfer(1'b0, 4'hF, 18'h00010, 32'h0, 7, 32'hABCD1234, "t6_read_after");

        chk("dq_oe_vs_oe_n", 64'(oe_clash), 64'd0);
        chk("pulses_left", 64'(exp_pulse_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
